// File: rtl/macc_dot_ctrl_if.sv
// macc_dot_ctrl_if: input stream, DSP48 MACC bus and result stream of macc_dot_ctrl
// (m_beats exists only with MACC_CTRL_BEATCNT_EN)
interface macc_dot_ctrl_if #(
  parameter int WIDTH_A = 25,
  parameter int WIDTH_B = 18,
  parameter int WIDTH_P = 48
`ifdef MACC_CTRL_BEATCNT_EN
  , parameter int CNT_W = 16
`endif
);
  logic s_valid, s_ready, s_sub, s_last;
  logic [WIDTH_A-1:0] s_a, macc_a;
  logic [WIDTH_B-1:0] s_b, macc_b;
  logic [WIDTH_P-1:0] bias, macc_load_data, macc_p, m_data;
  logic macc_ce, macc_load, macc_addsb, macc_carryin;
  logic m_valid, m_ready;
`ifdef MACC_CTRL_BEATCNT_EN
  logic [CNT_W-1:0] m_beats;
`endif
  modport master (
    input s_valid, s_a, s_b, s_sub, s_last, bias, macc_p, m_ready,
    output s_ready, macc_ce, macc_load, macc_load_data, macc_addsb, macc_carryin,
    output macc_a, macc_b, m_valid, m_data
`ifdef MACC_CTRL_BEATCNT_EN
    , output m_beats
`endif
  );
  modport slave (
    output s_valid, s_a, s_b, s_sub, s_last, bias, macc_p, m_ready,
    input s_ready, macc_ce, macc_load, macc_load_data, macc_addsb, macc_carryin,
    input macc_a, macc_b, m_valid, m_data
`ifdef MACC_CTRL_BEATCNT_EN
    , input m_beats
`endif
  );
endinterface

// File: rtl/macc_dot_ctrl.sv
// macc_dot_ctrl: sequences framed (a,b) beats into a DSP48 MACC and emits one dot product per frame
// Optional MACC_CTRL_BEATCNT_EN adds a saturating per-frame beat count on m_beats.
module macc_dot_ctrl #(
  parameter int WIDTH_A = 25,
  parameter int WIDTH_B = 18,
  parameter int WIDTH_P = 48,
  parameter int LATENCY = 3
`ifdef MACC_CTRL_BEATCNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input logic clk,
  input logic rst,
  macc_dot_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;
  state_t state, state_nx;
  logic [2:0] wait_cnt;
  logic accept, first, expired, capture;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    bus.s_ready = state != DRAIN;
    accept = bus.s_ready & bus.s_valid;
    first = accept & state == IDLE;
    expired = wait_cnt == 3'(LATENCY);
    capture = state == DRAIN & expired & (!bus.m_valid | bus.m_ready);
    state_nx = capture ? IDLE : accept ? (bus.s_last ? DRAIN : ACCUM) : state;
  end
  // Idle cycles feed zeros with add so the accumulator stays put while draining.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.macc_ce <= 1'b1;
      bus.macc_load <= 1'b0;
      bus.macc_load_data <= WIDTH_P'(0);
      bus.macc_addsb <= 1'b1;
      bus.macc_carryin <= 1'b0;
      bus.macc_a <= WIDTH_A'(0);
      bus.macc_b <= WIDTH_B'(0);
      bus.m_valid <= 1'b0;
      bus.m_data <= WIDTH_P'(0);
      wait_cnt <= 3'd0;
    end else begin
      bus.macc_ce <= 1'b1;
      bus.macc_load <= first;
      bus.macc_load_data <= first ? bus.bias : WIDTH_P'(0);
      bus.macc_addsb <= !(accept & bus.s_sub);
      bus.macc_carryin <= 1'b0;
      bus.macc_a <= accept ? bus.s_a : WIDTH_A'(0);
      bus.macc_b <= accept ? bus.s_b : WIDTH_B'(0);
      bus.m_valid <= capture | bus.m_valid & !bus.m_ready;
      if (capture) bus.m_data <= bus.macc_p;
      wait_cnt <= state != DRAIN ? 3'd0 : expired ? wait_cnt : wait_cnt + 3'd1;
    end
`ifdef MACC_CTRL_BEATCNT_EN
  logic [CNT_W-1:0] beats;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      beats <= '0;
      bus.m_beats <= '0;
    end else begin
      if (accept) beats <= first ? CNT_W'(1) : &beats ? beats : beats + 1'b1;
      if (capture) bus.m_beats <= beats;
    end
`endif
endmodule

// File: tb/tb_macc_dot_ctrl.sv
// tb_macc_dot_ctrl: scoreboard bench for macc_dot_ctrl driving a behavioural DSP48 MACC model
`timescale 1ns/1ps
module tb_macc_dot_ctrl;
  localparam int LAT = 3;
  logic clk = 1'b0, rst = 1'b1;
  int tests = 0, fails = 0, cyc = 0, last_acc = 0;
  logic [47:0] q[$];
  logic [47:0] held;
  logic signed [47:0] acc;
  logic chk_lat = 1'b0, mv_prev = 1'b0, hold = 1'b0, first = 1'b1;
  macc_dot_ctrl_if bus();
  macc_dot_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  typedef struct packed {logic load; logic addsb; logic [47:0] ld; logic [24:0] a; logic [17:0] b;} mop_t;
  mop_t pipe [LAT-1];
  logic signed [47:0] p = '0;
  assign bus.macc_p = p;
  function automatic logic signed [47:0] mul(mop_t o);
    return $signed(o.a) * $signed(o.b);
  endfunction
  always @(posedge clk)
    if (bus.macc_ce) begin
      pipe[0] <= {bus.macc_load, bus.macc_addsb, bus.macc_load_data, bus.macc_a, bus.macc_b};
      for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
      p <= (pipe[LAT-2].load ? $signed(pipe[LAT-2].ld) : p) +
           (pipe[LAT-2].addsb ? mul(pipe[LAT-2]) : -mul(pipe[LAT-2]));
    end
  always @(negedge clk)
    if (rst) begin
      hold <= 1'b0;
      mv_prev <= 1'b0;
    end else begin
      if (bus.s_valid & bus.s_ready & bus.s_last) last_acc <= cyc;
      if (hold) chk("hold", {bus.m_valid, bus.m_data}, {1'b1, held});
      if (chk_lat & bus.m_valid & !mv_prev) chk("latency", cyc - last_acc, LAT + 2);
      if (bus.m_valid & bus.m_ready) begin
        chk("queued", q.size() > 0, 1);
        if (q.size() > 0) chk("data", bus.m_data, q.pop_front());
      end
      hold <= bus.m_valid & !bus.m_ready;
      held <= bus.m_data;
      mv_prev <= bus.m_valid;
    end
  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic beat(int a, int b, bit sub, bit last, int bs);
    int n = 0;
    if (first) acc = 48'(bs);
    acc = sub ? acc - a * b : acc + a * b;
    if (last) q.push_back(acc);
    first = last;
    bus.s_valid = 1'b1;
    bus.s_a = 25'(a);
    bus.s_b = 18'(b);
    bus.s_sub = sub;
    bus.s_last = last;
    bus.bias = 48'(bs);
    @(negedge clk);
    while (!bus.s_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("accept_timeout", bus.s_ready, 1);
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
  endtask
  task automatic frame1(bit gaps);
    for (int i = 1; i <= 4; i++) begin
      beat(i, 2, 1'b0, i == 4, 10);
      if (gaps) idle(1);
    end
  endtask
  task automatic wait_drain();
    int n = 0;
    while ((q.size() > 0 || bus.m_valid) && n < 200) begin @(negedge clk); n++; end
    chk("drain", q.size(), 0);
    @(posedge clk); #1;
  endtask
  initial begin
    int n;
    bus.s_valid = 1'b0; bus.s_a = '0; bus.s_b = '0; bus.s_sub = 1'b0; bus.s_last = 1'b0;
    bus.bias = '0; bus.m_ready = 1'b1;
    #12;
    chk("rst_s_ready", bus.s_ready, 1);
    chk("rst_ce", bus.macc_ce, 1);
    chk("rst_load", bus.macc_load, 0);
    chk("rst_load_data", bus.macc_load_data, 0);
    chk("rst_addsb", bus.macc_addsb, 1);
    chk("rst_carryin", bus.macc_carryin, 0);
    chk("rst_a", bus.macc_a, 0);
    chk("rst_b", bus.macc_b, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_data", bus.m_data, 0);
    @(posedge clk); #1 rst = 1'b0;
    idle(2);
    chk_lat = 1'b1;
    frame1(1'b0);
    wait_drain();
    chk_lat = 1'b0;
    beat(-3, 7, 1'b0, 1'b1, 0);
    wait_drain();
    beat(5, 5, 1'b0, 1'b0, 0);
    beat(3, 3, 1'b1, 1'b1, 0);
    wait_drain();
    frame1(1'b1);
    wait_drain();
    bus.m_ready = 1'b0;
    frame1(1'b0);
    beat(-3, 7, 1'b0, 1'b1, 0);
    idle(12);
    chk("stall_s_ready", bus.s_ready, 0);
    chk("stall_m_valid", bus.m_valid, 1);
    chk("stall_m_data", bus.m_data, 48'd30);
    bus.m_ready = 1'b1;
    wait_drain();
    bus.m_ready = 1'b0;
    beat(-3, 7, 1'b0, 1'b1, 0);
    n = 0;
    while (!bus.m_valid && n < 50) begin @(negedge clk); n++; end
    chk("pre_rst_m_valid", bus.m_valid, 1);
    @(posedge clk); #1;
    beat(1, 2, 1'b0, 1'b0, 10);
    beat(2, 2, 1'b0, 1'b0, 10);
    #2 rst = 1'b1;
    #1;
    chk("async_m_valid", bus.m_valid, 0);
    chk("async_s_ready", bus.s_ready, 1);
    chk("async_m_data", bus.m_data, 0);
    q.delete();
    first = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    bus.m_ready = 1'b1;
    frame1(1'b0);
    wait_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
